// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Operands are captured at Start; the result commits after a fixed cycle count.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  HiLoWr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [1:0]       op_md;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [31:0]      hi_val;
    logic [31:0]      lo_val;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] result;
    logic        write_res;

    // Result datapath from the captured operands; division works on magnitudes then restores signs.
    always_comb begin
        prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        prod_u = {32'd0, op_a} * {32'd0, op_b};
        neg_a  = ~op_md[0] & op_a[31];
        neg_b  = ~op_md[0] & op_b[31];
        abs_a  = neg_a ? (32'd0 - op_a) : op_a;
        abs_b  = neg_b ? (32'd0 - op_b) : op_b;
        div_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag  = abs_a / div_b;
        r_mag  = abs_a % div_b;
        quot   = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem    = neg_a ? (32'd0 - r_mag) : r_mag;
        case (op_md)
            2'b00:   result = prod_s;
            2'b01:   result = prod_u;
            default: result = {rem, quot};
        endcase
        // A zero divisor still runs the full busy window but leaves HI/LO alone.
        write_res = ~op_md[1] | (op_b != 32'd0);
    end

    // Control FSM, operand capture and HI/LO updates.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            count  <= CNT_ZERO;
            Busy   <= 1'b0;
            op_md  <= 2'b00;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            hi_val <= 32'd0;
            lo_val <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_md <= MDOp;
                        op_a  <= A;
                        op_b  <= B;
                        Busy  <= 1'b1;
                        if (MDOp[1]) begin
                            state <= DIV;
                            count <= DIV_LOAD;
                        end else begin
                            state <= MULT;
                            count <= MULT_LOAD;
                        end
                    end else if (HiLoWr == 2'b01) begin
                        lo_val <= WData;
                    end else if (HiLoWr == 2'b10) begin
                        hi_val <= WData;
                    end
                end
                MULT, DIV: begin
                    if (count == CNT_ZERO) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (write_res) begin
                            hi_val <= result[63:32];
                            lo_val <= result[31:0];
                        end
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= CNT_ZERO;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Hi = hi_val;
    assign Lo = lo_val;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases with literal expectations plus
// randomized traffic compared every cycle against a cycle-count reference model.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  HiLoWr;
    logic [31:0] WData;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoWr(HiLoWr), .WData(WData), .Busy(Busy), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: HI/LO, cycles left in the current op, and the result it will commit.
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;
    int          m_left  = 0;
    logic [63:0] m_res   = 64'd0;
    logic        m_write = 1'b0;

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 2'b00) return 64'(sa * sb);
        else if (op == 2'b01) return ua * ub;
        else if (b == 32'd0) return 64'd0;
        else if (op == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end else return {a % b, a / b};
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_write) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end else if (Start) begin
            m_left  <= MDOp[1] ? DC : MC;
            m_res   <= ref_result(MDOp, A, B);
            m_write <= !(MDOp[1] && B == 32'd0);
        end else if (HiLoWr == 2'b01) begin
            m_lo <= WData;
        end else if (HiLoWr == 2'b10) begin
            m_hi <= WData;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        chk("model_busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
        chk("model_hi", Hi, m_hi);
        chk("model_lo", Lo, m_lo);
    end

    task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] wr, input logic [31:0] wd);
        Start = s; MDOp = op; A = a; B = b; HiLoWr = wr; WData = wd;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        HiLoWr = 2'b00;
        MDOp   = 2'($urandom);
        A      = $urandom;
        B      = $urandom;
        WData  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        Start = 1'b0; MDOp = 2'b00; A = 32'd0; B = 32'd0; HiLoWr = 2'b00; WData = 32'd0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", Hi, 32'd0);
        chk("reset_lo", Lo, 32'd0);

        // mult -3 * 7
        drive(1'b1, 2'b00, 32'hFFFFFFFD, 32'd7, 2'b00, 32'd0);
        chk("mult_busy_start", {31'd0, Busy}, 32'd1);
        idle(MC - 1);
        chk("mult_busy_last", {31'd0, Busy}, 32'd1);
        chk("mult_hi_hold", Hi, 32'd0);
        idle(1);
        chk("mult_busy_end", {31'd0, Busy}, 32'd0);
        chk("mult_hi", Hi, 32'hFFFFFFFF);
        chk("mult_lo", Lo, 32'hFFFFFFEB);

        // multu max * max
        drive(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'd0);
        idle(MC);
        chk("multu_hi", Hi, 32'hFFFFFFFE);
        chk("multu_lo", Lo, 32'h00000001);

        // div -7 / 2
        drive(1'b1, 2'b10, 32'hFFFFFFF9, 32'd2, 2'b00, 32'd0);
        idle(DC - 1);
        chk("div_busy_last", {31'd0, Busy}, 32'd1);
        idle(1);
        chk("div_busy_end", {31'd0, Busy}, 32'd0);
        chk("div_lo", Lo, 32'hFFFFFFFD);
        chk("div_hi", Hi, 32'hFFFFFFFF);

        // mthi/mtlo then divu by zero
        drive(1'b0, 2'b00, 32'd0, 32'd0, 2'b10, 32'h1234);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 2'b01, 32'h5678);
        chk("mthi", Hi, 32'h1234);
        chk("mtlo", Lo, 32'h5678);
        drive(1'b1, 2'b11, 32'd7, 32'd0, 2'b00, 32'd0);
        idle(DC - 1);
        chk("divz_busy_last", {31'd0, Busy}, 32'd1);
        idle(1);
        chk("divz_busy_end", {31'd0, Busy}, 32'd0);
        chk("divz_hi", Hi, 32'h1234);
        chk("divz_lo", Lo, 32'h5678);

        // signed overflow case
        drive(1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 2'b00, 32'd0);
        idle(DC);
        chk("ovf_lo", Lo, 32'h80000000);
        chk("ovf_hi", Hi, 32'd0);

        // Start and mtlo while busy are ignored
        drive(1'b1, 2'b10, 32'd100, 32'd7, 2'b00, 32'd0);
        drive(1'b1, 2'b01, 32'd2, 32'd3, 2'b00, 32'd0);
        drive(1'b0, 2'b00, 32'd0, 32'd0, 2'b01, 32'hDEAD);
        idle(DC - 3);
        chk("ign_busy_last", {31'd0, Busy}, 32'd1);
        idle(1);
        chk("ign_busy_end", {31'd0, Busy}, 32'd0);
        chk("ign_lo", Lo, 32'd14);
        chk("ign_hi", Hi, 32'd2);

        // Reset mid-op discards the result
        drive(1'b1, 2'b10, 32'd100, 32'd7, 2'b00, 32'd0);
        idle(2);
        #1 Reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_hi", Hi, 32'd0);
        chk("rst_mid_lo", Lo, 32'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        idle(DC + 2);
        chk("rst_late_hi", Hi, 32'd0);
        chk("rst_late_lo", Lo, 32'd0);

        // Randomized traffic, checked each cycle by the model
        for (int i = 0; i < 600; i++) begin
            ra = (($urandom % 8) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom % 8)
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom % 16);
                default: rb = 32'($urandom);
            endcase
            drive((($urandom % 3) == 0), 2'($urandom), ra, rb, 2'($urandom), 32'($urandom));
            if (($urandom % 150) == 0) begin
                #1 Reset = 1'b1;
                #2 Reset = 1'b0;
            end
        end
        idle(DC + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
